// File: rtl/numeros_pkg.sv
// numeros_pkg: operand interpretation modes and width helper shared by the accumulators
package numeros_pkg;

    localparam logic [1:0] MODO_SS = 2'd0;
    localparam logic [1:0] MODO_UU = 2'd1;
    localparam logic [1:0] MODO_US = 2'd2;
    localparam logic [1:0] MODO_SU = 2'd3;

    function automatic int max_largura(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/extensor_somador.sv
// extensor_somador: extends A and B per mode code to TERMO bits and adds them
module extensor_somador
    import numeros_pkg::*;
#(
    parameter int LARGURA_A = 8,
    parameter int LARGURA_B = 4,
    parameter int TERMO     = max_largura(LARGURA_A, LARGURA_B) + 2
) (
    input  logic [LARGURA_A-1:0] a,
    input  logic [LARGURA_B-1:0] b,
    input  logic [1:0]           codigo,
    output logic [TERMO-1:0]     termo
);

    logic a_sinal, b_sinal;
    logic [TERMO-1:0] ext_a, ext_b;

    // sign-extend signed operands, zero-extend unsigned ones, then add; TERMO leaves room so the sum never overflows
    always_comb begin
        a_sinal = (codigo == MODO_SS) || (codigo == MODO_SU);
        b_sinal = (codigo == MODO_SS) || (codigo == MODO_US);
        ext_a   = {{(TERMO-LARGURA_A){a_sinal & a[LARGURA_A-1]}}, a};
        ext_b   = {{(TERMO-LARGURA_B){b_sinal & b[LARGURA_B-1]}}, b};
        termo   = ext_a + ext_b;
    end

endmodule

// File: rtl/acumulador_com_sinal.sv
// acumulador_com_sinal: two-stage mixed-sign accumulator with wrap/saturate, sticky overflow and sample counter
module acumulador_com_sinal
    import numeros_pkg::*;
#(
    parameter int LARGURA_A    = 8,
    parameter int LARGURA_B    = 4,
    parameter int LARGURA_ACC  = 16,
    parameter int LARGURA_CONT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    entrada_valida,
    input  logic [LARGURA_A-1:0]    entrada_a,
    input  logic [LARGURA_B-1:0]    entrada_b,
    input  logic [1:0]              codigo,
    input  logic                    saturar,
    input  logic                    limpar,
    output logic [LARGURA_ACC-1:0]  saida,
    output logic                    saida_valida,
    output logic                    estouro,
    output logic [LARGURA_CONT-1:0] contador
);

    localparam int TERMO = max_largura(LARGURA_A, LARGURA_B) + 2;
    localparam logic [LARGURA_ACC-1:0] MAXIMO = {1'b0, {(LARGURA_ACC-1){1'b1}}};
    localparam logic [LARGURA_ACC-1:0] MINIMO = {1'b1, {(LARGURA_ACC-1){1'b0}}};

    logic [TERMO-1:0]       termo, termo_r;
    logic                   sat_r, val_r;
    logic [LARGURA_ACC:0]   soma;
    logic                   ovf;
    logic [LARGURA_ACC-1:0] proximo;

    extensor_somador #(
        .LARGURA_A(LARGURA_A),
        .LARGURA_B(LARGURA_B),
        .TERMO    (TERMO)
    ) u_ext (
        .a     (entrada_a),
        .b     (entrada_b),
        .codigo(codigo),
        .termo (termo)
    );

    // one guard bit above the total exposes overflow as a disagreement of the top two bits
    always_comb begin
        soma    = {saida[LARGURA_ACC-1], saida}
                + {{(LARGURA_ACC+1-TERMO){termo_r[TERMO-1]}}, termo_r};
        ovf     = soma[LARGURA_ACC] != soma[LARGURA_ACC-1];
        proximo = (ovf && sat_r) ? (soma[LARGURA_ACC] ? MINIMO : MAXIMO) : soma[LARGURA_ACC-1:0];
    end

    // stage 1 captures the term; stage 2 folds it into the total, flag and counter; limpar drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            termo_r      <= '0;
            sat_r        <= 1'b0;
            val_r        <= 1'b0;
            saida        <= '0;
            saida_valida <= 1'b0;
            estouro      <= 1'b0;
            contador     <= '0;
        end else if (limpar) begin
            val_r        <= 1'b0;
            saida        <= '0;
            saida_valida <= 1'b0;
            estouro      <= 1'b0;
            contador     <= '0;
        end else begin
            val_r        <= entrada_valida;
            saida_valida <= val_r;
            if (entrada_valida) begin
                termo_r <= termo;
                sat_r   <= saturar;
            end
            if (val_r) begin
                saida    <= proximo;
                estouro  <= estouro | ovf;
                contador <= (&contador) ? contador : contador + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acumulador_com_sinal.sv
// tb_acumulador_com_sinal: directed checks of modes, saturation/wrap, counter, limpar and async reset
module tb_acumulador_com_sinal;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        entrada_valida = 1'b0;
    logic [7:0]  entrada_a = '0;
    logic [3:0]  entrada_b = '0;
    logic [1:0]  codigo = '0;
    logic        saturar = 1'b0;
    logic        limpar = 1'b0;
    logic [15:0] saida;
    logic        saida_valida;
    logic        estouro;
    logic [7:0]  contador;

    int total = 0;
    int bad = 0;

    acumulador_com_sinal dut (
        .clk           (clk),
        .rst           (rst),
        .entrada_valida(entrada_valida),
        .entrada_a     (entrada_a),
        .entrada_b     (entrada_b),
        .codigo        (codigo),
        .saturar       (saturar),
        .limpar        (limpar),
        .saida         (saida),
        .saida_valida  (saida_valida),
        .estouro       (estouro),
        .contador      (contador)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reinicia();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic carrega(input logic [7:0] a, input logic [3:0] b, input logic [1:0] c, input logic s);
        entrada_a = a;
        entrada_b = b;
        codigo = c;
        saturar = s;
        entrada_valida = 1'b1;
    endtask

    task automatic rajada(input int n, input logic [7:0] a, input logic [3:0] b, input logic [1:0] c, input logic s);
        carrega(a, b, c, s);
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 2) check("vld_continuo", 32'(saida_valida), 32'h1);
        end
        entrada_valida = 1'b0;
        tick();
    endtask

    logic [15:0] modo_esp [4] = '{16'hFFEF, 16'h00FF, 16'h00EF, 16'hFFFF};

    initial begin
        #12;
        check("rst_saida", 32'(saida), 32'h0);
        check("rst_vld", 32'(saida_valida), 32'h0);
        check("rst_estouro", 32'(estouro), 32'h0);
        check("rst_contador", 32'(contador), 32'h0);
        rst = 1'b0;
        tick();

        for (int m = 0; m < 4; m++) begin
            reinicia();
            carrega(8'hF0, 4'hF, 2'(m), 1'b0);
            tick();
            entrada_valida = 1'b0;
            check("modo_vld_antes", 32'(saida_valida), 32'h0);
            tick();
            check("modo_vld", 32'(saida_valida), 32'h1);
            check("modo_saida", 32'(saida), 32'(modo_esp[m]));
            check("modo_contador", 32'(contador), 32'h1);
            tick();
            check("modo_vld_depois", 32'(saida_valida), 32'h0);
            check("modo_saida_mantida", 32'(saida), 32'(modo_esp[m]));
        end

        reinicia();
        rajada(245, 8'h7F, 4'h7, 2'd1, 1'b1);
        check("sat_saida", 32'(saida), 32'h7FFF);
        check("sat_estouro", 32'(estouro), 32'h1);
        check("sat_contador", 32'(contador), 32'hF5);
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
        check("limpar_estouro", 32'(estouro), 32'h0);
        check("limpar_saida_sat", 32'(saida), 32'h0);

        reinicia();
        rajada(245, 8'h7F, 4'h7, 2'd1, 1'b0);
        check("wrap_saida", 32'(saida), 32'h803E);
        check("wrap_estouro", 32'(estouro), 32'h1);
        check("wrap_contador", 32'(contador), 32'hF5);

        reinicia();
        rajada(300, 8'h00, 4'h1, 2'd1, 1'b0);
        check("cont_sat", 32'(contador), 32'hFF);
        check("cont_saida", 32'(saida), 32'd300);
        check("cont_estouro", 32'(estouro), 32'h0);

        reinicia();
        carrega(8'h10, 4'h0, 2'd1, 1'b0);
        tick();
        entrada_valida = 1'b0;
        tick();
        check("pre_limpar", 32'(saida), 32'h10);
        carrega(8'h05, 4'h0, 2'd1, 1'b0);
        limpar = 1'b1;
        tick();
        entrada_valida = 1'b0;
        limpar = 1'b0;
        check("limpar_saida", 32'(saida), 32'h0);
        check("limpar_contador", 32'(contador), 32'h0);
        check("limpar_estouro2", 32'(estouro), 32'h0);
        check("limpar_vld", 32'(saida_valida), 32'h0);
        tick();
        check("limpar_vld_depois", 32'(saida_valida), 32'h0);
        check("limpar_descartada", 32'(saida), 32'h0);
        carrega(8'h03, 4'h0, 2'd1, 1'b0);
        tick();
        entrada_valida = 1'b0;
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
        tick();
        check("voo_descartado", 32'(saida), 32'h0);
        check("voo_vld", 32'(saida_valida), 32'h0);
        check("voo_contador", 32'(contador), 32'h0);

        reinicia();
        carrega(8'h10, 4'h0, 2'd1, 1'b0);
        tick();
        carrega(8'h05, 4'h0, 2'd1, 1'b0);
        tick();
        entrada_valida = 1'b0;
        check("pre_rst_saida", 32'(saida), 32'h10);
        check("pre_rst_vld", 32'(saida_valida), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_saida", 32'(saida), 32'h0);
        check("async_vld", 32'(saida_valida), 32'h0);
        check("async_contador", 32'(contador), 32'h0);
        #1;
        rst = 1'b0;
        tick();
        check("pos_rst_vld", 32'(saida_valida), 32'h0);
        check("pos_rst_saida", 32'(saida), 32'h0);
        tick();
        check("pos_rst_vld2", 32'(saida_valida), 32'h0);
        check("pos_rst_contador", 32'(contador), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
